// File: rtl/vram_arbiter.sv
// Text-mode VRAM arbiter: display character fetches own every 8th pixel slot,
// CPU reads/writes are squeezed into the remaining cycles.
module vram_arbiter #(
    parameter int ROWS = 30,
    parameter int COLS = 80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_valid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ready,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    output logic [11:0] vram_addr,
    output logic        vram_we,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata,
    output logic [19:0] disp_addr,
    output logic [7:0]  disp_char,
    output logic        disp_valid
);

    // state | meaning
    // IDLE  | ready for a new CPU request
    // ISSUE | latched op waits for a free (non-display) cycle, then drives the port
    // RDATA | VRAM read data returns; forwarded to the CPU with rvalid
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [11:0] hold_q, hold_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic [7:0]  char_q, char_d;
    logic        slot_q;
    logic [19:0] pa1_q, pa2_q;
    logic        pv1_q, pv2_q;

    logic        slot;
    logic        in_range;
    logic        issue;

    assign slot     = pix_valid && (pix_x[2:0] == 3'd0);
    assign in_range = (int'(addr_q[11:7]) < ROWS) && (int'(addr_q[6:0]) < COLS);

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        issue    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Out-of-range ops never touch the port, so they need not wait for a slot.
                if (!in_range) begin
                    if (!we_q) begin
                        rdata_d  = 8'h00;
                        rvalid_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (!slot) begin
                    issue   = 1'b1;
                    state_d = we_q ? IDLE : RDATA;
                end
            end
            RDATA: begin
                rdata_d  = vram_rdata;
                rvalid_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vram_addr  = hold_q;
        vram_we    = 1'b0;
        vram_wdata = 8'h00;
        if (slot) begin
            vram_addr = {pix_y[8:4], pix_x[9:3]};
        end else if (issue) begin
            vram_addr  = addr_q;
            vram_we    = we_q;
            vram_wdata = wdata_q;
        end
        // Reset must force the port quiet immediately, not at the next edge.
        if (!rst_n) begin
            vram_addr  = 12'h000;
            vram_we    = 1'b0;
            vram_wdata = 8'h00;
        end
    end

    assign hold_d = vram_addr;
    assign char_d = slot_q ? vram_rdata : char_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= 12'h000;
            wdata_q  <= 8'h00;
            hold_q   <= 12'h000;
            rdata_q  <= 8'h00;
            rvalid_q <= 1'b0;
            char_q   <= 8'h00;
            slot_q   <= 1'b0;
            pa1_q    <= 20'h00000;
            pa2_q    <= 20'h00000;
            pv1_q    <= 1'b0;
            pv2_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            char_q   <= char_d;
            slot_q   <= slot;
            pa1_q    <= {pix_y, pix_x};
            pa2_q    <= pa1_q;
            pv1_q    <= pix_valid;
            pv2_q    <= pv1_q;
        end
    end

    assign cpu_ready  = rst_n && (state_q == IDLE);
    assign cpu_rdata  = rdata_q;
    assign cpu_rvalid = rvalid_q;
    assign disp_addr  = pa2_q;
    assign disp_char  = char_q;
    assign disp_valid = pv2_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural single-port VRAM
// (one-cycle read latency, read-before-write).
module tb_vram_arbiter;

    logic        clk;
    logic        rst_n;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic [11:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic [19:0] disp_addr;
    logic [7:0]  disp_char;
    logic        disp_valid;

    logic [7:0]  mem [0:4095];
    logic        preload;
    int          n_chk;
    int          n_fail;

    vram_arbiter #(.ROWS(30), .COLS(80)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_valid  (pix_valid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .vram_addr  (vram_addr),
        .vram_we    (vram_we),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .disp_addr  (disp_addr),
        .disp_char  (disp_char),
        .disp_valid (disp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem[12'h102] <= 8'h7A;
            mem[12'h103] <= 8'h55;
            mem[12'h050] <= 8'hEE;
            mem[12'hECF] <= 8'h3C;
            vram_rdata   <= 8'h00;
        end else begin
            if (vram_we) mem[vram_addr] <= vram_wdata;
            vram_rdata <= mem[vram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        preload   = 1'b1;
        rst_n     = 1'b0;
        pix_x     = 10'd8;
        pix_y     = 10'd16;
        pix_valid = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 12'h000;
        cpu_wdata = 8'h00;

        // Reset values, with a display slot presented on the pixel inputs
        tick();
        tick();
        preload = 1'b0;
        #1;
        chk("rst_ready",   32'(cpu_ready),  32'h0);
        chk("rst_rvalid",  32'(cpu_rvalid), 32'h0);
        chk("rst_rdata",   32'(cpu_rdata),  32'h00);
        chk("rst_we",      32'(vram_we),    32'h0);
        chk("rst_vaddr",   32'(vram_addr),  32'h000);
        chk("rst_dchar",   32'(disp_char),  32'h00);
        chk("rst_dvalid",  32'(disp_valid), 32'h0);
        chk("rst_daddr",   32'(disp_addr),  32'h00000);

        pix_valid = 1'b0;
        pix_x     = 10'd0;
        pix_y     = 10'd0;
        #1;
        rst_n = 1'b1;
        tick();
        #1;
        chk("idle_ready", 32'(cpu_ready), 32'h1);

        // Blanking: write 0x005 <= 0x41, then read it back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h005; cpu_wdata = 8'h41;
        #1;
        chk("wr_accept", 32'(cpu_ready), 32'h1);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("wr_issue_we",    32'(vram_we),    32'h1);
        chk("wr_issue_addr",  32'(vram_addr),  32'h005);
        chk("wr_issue_data",  32'(vram_wdata), 32'h41);
        chk("wr_issue_ready", 32'(cpu_ready),  32'h0);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h005;
        #1;
        chk("wr_done_we",    32'(vram_we),   32'h0);
        chk("idle_hold",     32'(vram_addr), 32'h005);
        chk("rd_accept",     32'(cpu_ready), 32'h1);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("rd_issue_addr", 32'(vram_addr),  32'h005);
        chk("rd_issue_we",   32'(vram_we),    32'h0);
        tick();
        #1;
        chk("rd_rvalid_early", 32'(cpu_rvalid), 32'h0);
        tick();
        #1;
        chk("rd_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("rd_rdata",  32'(cpu_rdata),  32'h41);
        tick();
        #1;
        chk("rd_rvalid_pulse", 32'(cpu_rvalid), 32'h0);

        // Display fetch at (16,35): cell 0x102, then cell 0x103 from x=24
        pix_valid = 1'b1;
        pix_y     = 10'd35;
        for (int i = 0; i < 15; i++) begin
            pix_x = 10'(16 + i);
            #1;
            if (i == 0) begin
                chk("slot_vaddr", 32'(vram_addr), 32'h102);
                chk("slot_we",    32'(vram_we),   32'h0);
            end
            if (i >= 2) begin
                chk("disp_addr",  32'(disp_addr),  32'({10'd35, 10'(16 + i - 2)}));
                chk("disp_valid", 32'(disp_valid), 32'h1);
                chk("disp_char",  32'(disp_char),  (16 + i - 2 < 24) ? 32'h7A : 32'h55);
            end
            tick();
        end

        // Write accepted at x=31, stalled by slot x=32, issued at x=33
        pix_x = 10'd31;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h006; cpu_wdata = 8'h99;
        #1;
        chk("stall_accept", 32'(cpu_ready), 32'h1);
        tick();
        pix_x = 10'd32;
        cpu_req = 1'b0;
        #1;
        chk("stall_slot_addr", 32'(vram_addr), 32'h104);
        chk("stall_slot_we",   32'(vram_we),   32'h0);
        chk("stall_ready",     32'(cpu_ready), 32'h0);
        tick();
        pix_x = 10'd33;
        #1;
        chk("stall_issue_we",   32'(vram_we),    32'h1);
        chk("stall_issue_addr", 32'(vram_addr),  32'h006);
        chk("stall_issue_data", 32'(vram_wdata), 32'h99);
        tick();
        pix_x = 10'd34;
        #1;
        chk("stall_done_we",    32'(vram_we),   32'h0);
        chk("stall_done_ready", 32'(cpu_ready), 32'h1);
        chk("stall_mem",        32'(mem[12'h006]), 32'h99);

        // Range checks during blanking
        pix_valid = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'hF00; cpu_wdata = 8'h11;
        tick();
        cpu_req = 1'b0;
        #1;
        chk("oor_wr_we1",   32'(vram_we),   32'h0);
        chk("oor_wr_ready", 32'(cpu_ready), 32'h0);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h050;
        #1;
        chk("oor_wr_we2",    32'(vram_we),   32'h0);
        chk("oor_rd_accept", 32'(cpu_ready), 32'h1);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("oor_rd_we",     32'(vram_we),    32'h0);
        chk("oor_rd_noaddr", 32'(vram_addr == 12'h050), 32'h0);
        chk("oor_rd_early",  32'(cpu_rvalid), 32'h0);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'hECF;
        #1;
        chk("oor_rd_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("oor_rd_rdata",  32'(cpu_rdata),  32'h00);
        chk("oor_wr_mem",    32'(mem[12'hF00]), 32'h00);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("edge_rd_addr", 32'(vram_addr), 32'hECF);
        tick();
        tick();
        #1;
        chk("edge_rd_rvalid", 32'(cpu_rvalid), 32'h1);
        chk("edge_rd_rdata",  32'(cpu_rdata),  32'h3C);

        // Reset while a write is stalled in ISSUE by a display slot
        tick();
        pix_valid = 1'b1;
        pix_x = 10'd39;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h007; cpu_wdata = 8'h77;
        tick();
        pix_x = 10'd40;
        cpu_req = 1'b0;
        #1;
        chk("rstmid_slot_addr", 32'(vram_addr), 32'h105);
        chk("rstmid_ready",     32'(cpu_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_we",     32'(vram_we),    32'h0);
        chk("rstmid_vaddr",  32'(vram_addr),  32'h000);
        chk("rstmid_rdata",  32'(cpu_rdata),  32'h00);
        chk("rstmid_dchar",  32'(disp_char),  32'h00);
        chk("rstmid_dvalid", 32'(disp_valid), 32'h0);
        pix_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        chk("post_ready",  32'(cpu_ready),  32'h1);
        chk("post_daddr",  32'(disp_addr),  32'h00000);
        chk("post_vaddr",  32'(vram_addr),  32'h000);
        for (int i = 0; i < 4; i++) begin
            chk("post_we",     32'(vram_we),    32'h0);
            chk("post_rvalid", 32'(cpu_rvalid), 32'h0);
            tick();
        end
        chk("post_mem", 32'(mem[12'h007]), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
